// File: rtl/round_robin_sel_if.sv
// Request/grant bundle between the requesters and the round-robin selector.
// With ARB_LOCK_EN defined the bundle also carries the lock input.
interface round_robin_sel_if;
    logic [3:0] req;
    logic [1:0] SEL;
    logic [3:0] grant;
    logic       valid;
    logic       new_grant;
`ifdef ARB_LOCK_EN
    logic       lock;

    modport master (output req, output lock, input SEL, input grant, input valid, input new_grant);
    modport slave  (input req, input lock, output SEL, output grant, output valid, output new_grant);
`else
    modport master (output req, input SEL, input grant, input valid, input new_grant);
    modport slave  (input req, output SEL, output grant, output valid, output new_grant);
`endif
endinterface

// File: rtl/round_robin_sel.sv
// Round-robin selector driving the 4:1 router select with bounded grant hold.
// Optional feature macro ARB_LOCK_EN adds a lock input that suppresses hold expiry.
module round_robin_sel #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    round_robin_sel_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             new_q, new_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;
    logic             any_req;
    logic             lock_on;
    logic             hold_hit;
    logic             release_now;
    logic             start;

`ifdef ARB_LOCK_EN
    assign lock_on = bus.lock & valid_q;
`else
    assign lock_on = 1'b0;
`endif

    assign any_req     = |bus.req;
    assign hold_hit    = (cnt_q == HOLD_MAX) && !lock_on;
    assign release_now = hold_hit || !bus.req[last_q];

    // Scan last+1 .. last+4 (mod 4) so the current owner is considered last.
    always_comb begin
        winner = last_q;
        cand   = last_q;
        found  = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state   <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            new_q   <= new_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (any_req) state_d = GRANT;
            GRANT:   if (release_now && !any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        new_d   = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        start   = any_req && ((state == IDLE) || release_now);
        if (start) begin
            sel_d   = winner;
            grant_d = 4'b0001 << winner;
            valid_d = 1'b1;
            new_d   = 1'b1;
            cnt_d   = '0;
            last_d  = winner;
        end else if (state == GRANT && release_now) begin
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (state == GRANT) begin
            // Saturate so a locked grant releases on the first edge after unlock.
            cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    assign bus.SEL       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.valid     = valid_q;
    assign bus.new_grant = new_q;

endmodule

// File: tb/tb_round_robin_sel.sv
// Directed-vector bench for round_robin_sel at HOLD_CYCLES of 4, 3 and 1.
module tb_round_robin_sel;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    round_robin_sel_if bif4();
    round_robin_sel_if bif3();
    round_robin_sel_if bif1();

    round_robin_sel #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (.clock(clock), .reset(reset), .bus(bif4));
    round_robin_sel #(.HOLD_CYCLES(3), .CNT_W(8)) u_dut3 (.clock(clock), .reset(reset), .bus(bif3));
    round_robin_sel #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (.clock(clock), .reset(reset), .bus(bif1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check4(input string tag, input logic [1:0] sel, input logic [3:0] gnt,
                          input logic vld, input logic ng);
        check({tag, ".sel"},   32'(bif4.SEL),       32'(sel));
        check({tag, ".grant"}, 32'(bif4.grant),     32'(gnt));
        check({tag, ".valid"}, 32'(bif4.valid),     32'(vld));
        check({tag, ".new"},   32'(bif4.new_grant), 32'(ng));
    endtask

    initial begin
        logic [1:0] idx;
        logic [3:0] oh;

        bif4.req = '0;
        bif3.req = '0;
        bif1.req = '0;
`ifdef ARB_LOCK_EN
        bif4.lock = 1'b0;
        bif3.lock = 1'b0;
        bif1.lock = 1'b0;
`endif

        step();
        check4("reset", 2'b00, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;

        // Round robin over all four sources, four cycles each
        bif4.req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            idx = 2'((k / 4) % 4);
            oh  = 4'b0001 << idx;
            check4($sformatf("rr%0d", k), idx, oh, 1'b1, (k % 4) == 0);
        end

        // A just finished its 4th cycle; B wins next, then drops early
        bif4.req = 4'b1110;
        step();
        check4("drop_b1", 2'b01, 4'b0010, 1'b1, 1'b1);
        step();
        check4("drop_b2", 2'b01, 4'b0010, 1'b1, 1'b0);
        bif4.req = 4'b1100;
        step();
        check4("drop_c", 2'b10, 4'b0100, 1'b1, 1'b1);

        // Idle return with SEL held, then scan resumes after C
        bif4.req = 4'b0000;
        step();
        check4("idle1", 2'b10, 4'b0000, 1'b0, 1'b0);
        step();
        check4("idle2", 2'b10, 4'b0000, 1'b0, 1'b0);
        bif4.req = 4'b0011;
        step();
        check4("after_idle", 2'b00, 4'b0001, 1'b1, 1'b1);
        bif4.req = 4'b0000;
        step();
        check4("idle3", 2'b00, 4'b0000, 1'b0, 1'b0);

        // Asynchronous reset mid-grant
        bif4.req = 4'b0100;
        step();
        check4("pre_rst", 2'b10, 4'b0100, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check4("async_rst", 2'b00, 4'b0000, 1'b0, 1'b0);
        reset    = 1'b0;
        bif4.req = 4'b0001;
        step();
        check4("post_rst", 2'b00, 4'b0001, 1'b1, 1'b1);
        bif4.req = 4'b0000;
        step();

        // Sole requester D on the HOLD_CYCLES=3 instance
        bif3.req = 4'b1000;
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("sole%0d.sel", k),   32'(bif3.SEL),       32'd3);
            check($sformatf("sole%0d.grant", k), 32'(bif3.grant),     32'h8);
            check($sformatf("sole%0d.valid", k), 32'(bif3.valid),     32'd1);
            check($sformatf("sole%0d.new", k),   32'(bif3.new_grant), 32'((k % 3) == 0));
        end
        bif3.req = 4'b0000;

        // HOLD_CYCLES=1 rotates every cycle
        bif1.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            idx = 2'(k % 4);
            oh  = 4'b0001 << idx;
            check($sformatf("h1_%0d.grant", k), 32'(bif1.grant),     32'(oh));
            check($sformatf("h1_%0d.sel", k),   32'(bif1.SEL),       32'(idx));
            check($sformatf("h1_%0d.new", k),   32'(bif1.new_grant), 32'd1);
        end
        bif1.req = 4'b0000;
        step();
        check("h1_idle.valid", 32'(bif1.valid), 32'd0);

`ifdef ARB_LOCK_EN
        // Lock keeps A beyond the hold limit; unlock releases at the next edge
        reset = 1'b1;
        step();
        reset     = 1'b0;
        bif4.lock = 1'b1;
        bif4.req  = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            step();
            check4($sformatf("lock%0d", k), 2'b00, 4'b0001, 1'b1, k == 0);
        end
        bif4.lock = 1'b0;
        step();
        check4("unlock", 2'b01, 4'b0010, 1'b1, 1'b1);
        bif4.req = 4'b0000;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_robin_sel.md
Name: round_robin_sel

Overview:
- Upstream control stage for the 4:1 bus router (4-bit sources A, B, C, D; 2-bit select).
- Arbitrates four request lines with a round-robin policy and drives the router's select code.
- Holds each grant for a bounded number of cycles, or until the owner drops its request.
- Outputs are registered, so the router sees a stable select for the whole grant window.

Parameters:
- HOLD_CYCLES, 4: maximum consecutive cycles one source keeps the grant. Legal range 1..255.
- CNT_W, 8: width of the internal hold counter. Must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per source; bit 0 = A, bit 1 = B, bit 2 = C, bit 3 = D.
- SEL  output  2  select code for the router; 00=A, 01=B, 10=C, 11=D.
- grant  output  4  one-hot owner of the bus; all zero when idle.
- valid  output  1  high while a grant is active, i.e. the router output carries owner data.
- new_grant  output  1  one-cycle pulse on the first cycle of each new grant.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, SEL=2'b00, grant=4'b0000, valid=0, new_grant=0, hold counter=0, last-owner pointer=3. The pointer value 3 makes the first search start at source 0. Reset asserted mid-grant aborts the grant immediately, without waiting for a clock edge.
- Search order: scan from (last+1) mod 4 upward with wrap-around; take the first set bit of req. The current owner is checked last.
- State IDLE:
  - req==0: remain in IDLE. SEL keeps its last value; grant=0; valid=0.
  - req!=0: at the sampling edge, register the winner. SEL=winner, grant=onehot(winner), valid=1, new_grant=1, counter=0, pointer=winner. Next state GRANT.
  - Latency from req seen high at an edge to grant/valid high is 1 cycle.
- State GRANT (counter increments every cycle). Release condition at an edge: counter==HOLD_CYCLES-1, OR req[owner]==0.
  - Release with another request pending: select the next winner in the same edge. Back-to-back grant, no idle bubble; new_grant=1 again.
  - Release, and the owner is the only requester and still requesting: the owner is re-granted. new_grant pulses again and the counter restarts.
  - Release with req==0: go to IDLE. grant=0, valid=0, SEL holds.
  - No release: outputs unchanged; new_grant=0.
- new_grant is 1 only on the first cycle of each grant. It is never high while valid=0.
- HOLD_CYCLES=1: every grant lasts exactly one cycle, so requesters rotate every cycle.
- Simultaneous requests: the winner depends only on the pointer, never on bit index alone.
- Invariants: grant is always one-hot or zero. When valid=1, grant==onehot(SEL).

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1 and valid=1, the hold-count release is suppressed. The counter saturates at HOLD_CYCLES-1 and the owner keeps the grant indefinitely.
  - Dropping req[owner] still releases the grant.
  - lock is ignored in IDLE.
- Undefined: no lock port; behaviour exactly as above.

Test Plan:
- Reset behaviour: assert reset mid-grant (owner=2) between clock edges -> SEL=00, grant=0000, valid=0 immediately. After release, req=0001 -> next cycle SEL=00, grant=0001, new_grant=1.
- Round-robin: HOLD_CYCLES=4, req=1111 held -> grant sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…; new_grant pulses every 4th cycle; valid stays 1.
- Early drop: owner B (SEL=01); deassert req[1] after 2 cycles while req=1100 -> next edge SEL=10, grant=0100, new_grant=1, with no idle cycle.
- Sole requester: req=1000 only, HOLD_CYCLES=3 -> SEL=11 continuous; new_grant pulses every 3 cycles; valid never drops.
- Idle return: owner C, req drops to 0000 -> grant=0000, valid=0, SEL stays 10. Later req=0011 -> grant=1000? no; the pointer is at 2, so the scan order is 3, 0, 1 -> grant=0001, SEL=00.
- ARB_LOCK_EN: owner A with lock=1 for 10 cycles, req=1111 -> grant stays 0001 for all 10 cycles. Drop lock -> release at the next edge, then grant=0010.
